fp_addsub_pipe: RTL and testbench

//  Parametrised, pipelined IEEE-754-style floating-point add/subtract unit; next generation of the single-cycle fp adder.

---
 rtl/fp_pkg.sv | 35 +++
 rtl/fp_lzc.sv | 31 +++
 rtl/fp_addsub_pipe.sv | 264 ++++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared types and default format constants for the pipelined
//                floating-point add/subtract unit.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    // Default binary32 format and the constants derived from it
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int W        = 1 + FP_EXP_W + FP_MAN_W;
    localparam int BIAS     = 2**(FP_EXP_W-1) - 1;
    localparam int EXP_MAX  = 2**FP_EXP_W - 1;

    // Operand class; also used as the result tag carried down the pipe
    // (FP_NORM = arithmetic result, FP_INF / FP_NAN = special bypass)
    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_e;

    // Exception flags, packed in port order {invalid, overflow, underflow, inexact}
    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fp_lzc
//  Description : Combinational leading-zero counter. An all-zero input
//                returns IN_W.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_lzc #(
    parameter int IN_W  = 27,
    parameter int CNT_W = $clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]  in_vec,
    output logic [CNT_W-1:0] lz_cnt
);

    logic w_found;

    // Scan from the MSB; the first set bit fixes the count
    always_comb begin
        lz_cnt  = CNT_W'(IN_W);
        w_found = 1'b0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (!w_found && in_vec[i]) begin
                lz_cnt  = CNT_W'(IN_W - 1 - i);
                w_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addsub_pipe
//  Description : 4-stage pipelined floating-point add/subtract with RNE
//                rounding, flush-to-zero, special-value bypass, exception
//                flags and a valid/ready stream handshake.
//                S1 unpack/swap, S2 align, S3 add/sub, S4 normalise/round/pack.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     op_a,
    input  logic [EXP_W+MAN_W:0]     op_b,
    input  logic                     op_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [3:0]               flags
);

    localparam int c_w       = 1 + EXP_W + MAN_W;
    localparam int c_sig_w   = MAN_W + 4;            // hidden + fraction + G,R,S
    localparam int c_sh_max  = MAN_W + 3;            // alignment shift saturation
    localparam int c_sh_w    = $clog2(c_sig_w);
    localparam int c_lz_w    = $clog2(c_sig_w + 1);
    localparam int c_xe_w    = EXP_W + 2;            // exponent working width, MSB = negative
    localparam int c_rnd_w   = MAN_W + 2;
    localparam int c_exp_max = 2**EXP_W - 1;

    typedef struct packed {
        fp_class_e          cls;
        logic               sign_l;
        logic               sign_s;
        logic [EXP_W-1:0]   exp_l;
        logic [EXP_W-1:0]   diff;
        logic [MAN_W:0]     sig_l;
        logic [MAN_W:0]     sig_s;
    } s1_t;

    typedef struct packed {
        fp_class_e          cls;
        logic               sign_l;
        logic               sign_s;
        logic [EXP_W-1:0]   exp_l;
        logic [c_sig_w-1:0] ext_l;
        logic [c_sig_w-1:0] ext_s;
    } s2_t;

    typedef struct packed {
        fp_class_e          cls;
        logic               sign_l;
        logic               sign_s;
        logic [EXP_W-1:0]   exp_l;
        logic [c_sig_w:0]   sum;
    } s3_t;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0)      return FP_ZERO;   // zero and subnormal (flushed)
        else if (e == '1) return (f == '0) ? FP_INF : FP_NAN;
        else              return FP_NORM;
    endfunction

    // ---------------------------------------------------------------- control
    logic w_en;
    logic r_v1, r_v2, r_v3, r_out_valid;

    assign w_en      = !r_out_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;

    // ---------------------------------------------------------------- S1
    logic                 w_sa, w_sb, w_swap;
    logic [EXP_W-1:0]     w_ea, w_eb, w_exp_s;
    logic [MAN_W-1:0]     w_fa, w_fb;
    logic [c_w-2:0]       w_mag_a, w_mag_b;
    logic [MAN_W:0]       w_sig_a, w_sig_b;
    fp_class_e            w_ca, w_cb;
    s1_t                  w_s1, r_s1;

    assign w_sa = op_a[c_w-1];
    assign w_sb = op_b[c_w-1] ^ op_sub;
    assign w_ea = op_a[c_w-2 -: EXP_W];
    assign w_eb = op_b[c_w-2 -: EXP_W];
    assign w_fa = op_a[MAN_W-1:0];
    assign w_fb = op_b[MAN_W-1:0];

    // Classify, flush subnormals, order operands so the first has the larger magnitude
    always_comb begin
        w_ca    = classify(w_ea, w_fa);
        w_cb    = classify(w_eb, w_fb);
        w_mag_a = (w_ca == FP_ZERO) ? '0 : op_a[c_w-2:0];
        w_mag_b = (w_cb == FP_ZERO) ? '0 : op_b[c_w-2:0];
        w_sig_a = (w_ca == FP_ZERO) ? '0 : {1'b1, w_fa};
        w_sig_b = (w_cb == FP_ZERO) ? '0 : {1'b1, w_fb};
        w_swap  = (w_mag_b > w_mag_a);

        w_s1.sign_l = w_swap ? w_sb    : w_sa;
        w_s1.sign_s = w_swap ? w_sa    : w_sb;
        w_s1.exp_l  = w_swap ? w_eb    : w_ea;
        w_exp_s     = w_swap ? w_ea    : w_eb;
        w_s1.sig_l  = w_swap ? w_sig_b : w_sig_a;
        w_s1.sig_s  = w_swap ? w_sig_a : w_sig_b;
        w_s1.diff   = w_s1.exp_l - w_exp_s;

        if (w_ca == FP_NAN || w_cb == FP_NAN || (w_ca == FP_INF && w_cb == FP_INF && w_sa != w_sb))
            w_s1.cls = FP_NAN;
        else if (w_ca == FP_INF || w_cb == FP_INF)
            w_s1.cls = FP_INF;      // the larger operand is the infinity
        else
            w_s1.cls = FP_NORM;
    end

    // ---------------------------------------------------------------- S2
    logic [c_sh_w-1:0]    w_sh;
    logic [c_sig_w-1:0]   w_ext_s, w_shifted, w_mask;
    logic                 w_lost;
    s2_t                  w_s2, r_s2;

    // Right-align the smaller significand, folding shifted-out bits into sticky
    always_comb begin
        w_sh      = (int'(r_s1.diff) > c_sh_max) ? c_sh_w'(c_sh_max) : c_sh_w'(r_s1.diff);
        w_ext_s   = {r_s1.sig_s, 3'b000};
        w_mask    = ~({c_sig_w{1'b1}} << w_sh);
        w_lost    = |(w_ext_s & w_mask);
        w_shifted = w_ext_s >> w_sh;

        w_s2.cls    = r_s1.cls;
        w_s2.sign_l = r_s1.sign_l;
        w_s2.sign_s = r_s1.sign_s;
        w_s2.exp_l  = r_s1.exp_l;
        w_s2.ext_l  = {r_s1.sig_l, 3'b000};
        w_s2.ext_s  = {w_shifted[c_sig_w-1:1], w_shifted[0] | w_lost};
    end

    // ---------------------------------------------------------------- S3
    s3_t                  w_s3, r_s3;

    // Magnitude add or subtract; operand order guarantees a non-negative difference
    always_comb begin
        w_s3.cls    = r_s2.cls;
        w_s3.sign_l = r_s2.sign_l;
        w_s3.sign_s = r_s2.sign_s;
        w_s3.exp_l  = r_s2.exp_l;
        if (r_s2.sign_l ^ r_s2.sign_s)
            w_s3.sum = {1'b0, r_s2.ext_l} - {1'b0, r_s2.ext_s};
        else
            w_s3.sum = {1'b0, r_s2.ext_l} + {1'b0, r_s2.ext_s};
    end

    // ---------------------------------------------------------------- S4
    logic [c_lz_w-1:0]    w_lz;
    logic [c_sig_w-1:0]   w_norm;
    logic [c_xe_w-1:0]    w_exp_n, w_exp_r;
    logic [c_rnd_w-1:0]   w_rnd;
    logic [MAN_W-1:0]     w_frac;
    logic                 w_up, w_grs, w_zero;
    logic [c_w-1:0]       w_res;
    fp_flags_t            w_flags;
    logic [c_w-1:0]       r_result;
    fp_flags_t            r_flags;

    fp_lzc #(
        .IN_W   (c_sig_w),
        .CNT_W  (c_lz_w)
    ) u_lzc (
        .in_vec (r_s3.sum[c_sig_w-1:0]),
        .lz_cnt (w_lz)
    );

    // Normalise, round to nearest even, then pick special / zero / inf / finite packing
    always_comb begin
        w_zero = (r_s3.sum == '0);
        if (r_s3.sum[c_sig_w]) begin
            w_norm  = {r_s3.sum[c_sig_w:2], r_s3.sum[1] | r_s3.sum[0]};
            w_exp_n = c_xe_w'(r_s3.exp_l) + c_xe_w'(1);
        end else begin
            w_norm  = r_s3.sum[c_sig_w-1:0] << w_lz;
            w_exp_n = c_xe_w'(r_s3.exp_l) - c_xe_w'(w_lz);
        end

        w_grs   = |w_norm[2:0];
        w_up    = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd   = {1'b0, w_norm[c_sig_w-1:3]} + c_rnd_w'(w_up);
        w_exp_r = w_exp_n + c_xe_w'(w_rnd[MAN_W+1]);
        w_frac  = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];

        w_flags = '0;
        case (r_s3.cls)
            FP_NAN: begin
                w_res           = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                w_flags.invalid = 1'b1;
            end
            FP_INF: begin
                w_res = {r_s3.sign_l, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
            default: begin
                if (w_zero) begin
                    // Exact zero is +0 unless both effective signs are negative
                    w_res = {r_s3.sign_l & r_s3.sign_s, {(c_w-1){1'b0}}};
                end else if (w_exp_n[c_xe_w-1] || w_exp_n == '0) begin
                    w_res             = {r_s3.sign_l, {(c_w-1){1'b0}}};
                    w_flags.underflow = 1'b1;
                    w_flags.inexact   = 1'b1;
                end else if (w_exp_r >= c_xe_w'(c_exp_max)) begin
                    w_res            = {r_s3.sign_l, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    w_flags.overflow = 1'b1;
                    w_flags.inexact  = 1'b1;
                end else begin
                    w_res           = {r_s3.sign_l, w_exp_r[EXP_W-1:0], w_frac};
                    w_flags.inexact = w_grs;
                end
            end
        endcase
    end

    // ---------------------------------------------------------------- registers
    // Stage valid bits advance together under the global enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_v1        <= in_valid;
            r_v2        <= r_v1;
            r_v3        <= r_v2;
            r_out_valid <= r_v3;
        end
    end

    // Intermediate stage data; contents of invalid stages are don't-care
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_s1 <= w_s1;
            r_s2 <= w_s2;
            r_s3 <= w_s3;
        end
    end

    // Output register only loads real results so it never changes under a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_en && r_v3) begin
            r_result <= w_res;
            r_flags  <= w_flags;
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_addsub_pipe
//  Description : Directed scoreboard bench for fp_addsub_pipe (binary32).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_addsub_pipe;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] op_a      = '0;
    logic [31:0] op_b      = '0;
    logic        op_sub    = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [3:0]  flags;

    fp_addsub_pipe #(
        .EXP_W     (8),
        .MAN_W     (23)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          acc_cyc;
        bit          chk_lat;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stall_lo = -1;
    int          stall_hi = -1;
    int          stall_seen = 0;
    bit          accepted = 0;
    bit          prev_stall = 0;
    logic [35:0] prev_out = '0;
    logic [31:0] nx_res = '0;
    logic [3:0]  nx_flg = '0;
    bit          nx_lat = 0;
    string       nx_tag = "";

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: set out_ready, sample handshakes at negedge, step past the posedge
    task automatic tick();
        exp_t e;
        out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
        @(negedge clk);
        accepted = 0;
        if (in_valid && in_ready) begin
            sb_q.push_back('{res: nx_res, flg: nx_flg, acc_cyc: cyc, chk_lat: nx_lat, tag: nx_tag});
            accepted = 1;
        end
        if (out_valid && !out_ready) begin
            stall_seen++;
            check("stall_in_ready", 64'(in_ready), 64'(0));
            if (prev_stall)
                check("stall_hold", 64'({result, flags}), 64'(prev_out));
            prev_stall = 1;
            prev_out   = {result, flags};
        end else begin
            prev_stall = 0;
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 64'(out_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check({e.tag, "_result"}, 64'(result), 64'(e.res));
                check({e.tag, "_flags"}, 64'(flags), 64'(e.flg));
                if (e.chk_lat)
                    check({e.tag, "_latency"}, 64'(cyc - e.acc_cyc), 64'(4));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] er, input logic [3:0] ef, input bit lat, input string tag);
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        nx_res = er; nx_flg = ef; nx_lat = lat; nx_tag = tag;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (accepted) break;
        end
        if (!accepted)
            check({tag, "_accept_timeout"}, 64'(in_ready), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (sb_q.size() == 0) break;
            tick();
        end
        check("drain_queue_empty", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_flags", 64'(flags), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Basic addition with latency
        send(32'h3FC00000, 32'h415B0000, 1'b0, 32'h41730000, 4'b0000, 1, "t1_add");
        drain();

        // Back-to-back add and exact cancellation
        send(32'h3F180000, 32'h415B0000, 1'b0, 32'h41648000, 4'b0000, 1, "t2_add");
        send(32'h415B0000, 32'h415B0000, 1'b1, 32'h00000000, 4'b0000, 1, "t2_cancel");
        drain();

        // Rounding ties
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 1, "t3_tie_even");
        send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 1, "t3_tie_up");
        drain();

        // Overflow, invalid, FTZ and other specials
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 1, "t4_overflow");
        send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 1, "t4_inf_minus_inf");
        send(32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 1, "t4_ftz");
        send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 1, "t4_inf_fin");
        send(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 1, "t4_ninf_fin");
        send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 1, "t4_nan_in");
        send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1, "t4_nz_plus_nz");
        send(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, 1, "t4_nz_minus_pz");
        send(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011, 1, "t4_underflow");
        drain();

        // Back-to-back burst with a downstream stall
        stall_seen = 0;
        stall_lo   = cyc + 3;
        stall_hi   = cyc + 6;
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 0, "t5_0");
        send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000, 0, "t5_1");
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 0, "t5_2");
        send(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000, 0, "t5_3");
        send(32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000, 0, "t5_4");
        send(32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 4'b0000, 0, "t5_5");
        send(32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 4'b0000, 0, "t5_6");
        send(32'hC0000000, 32'hC0000000, 1'b0, 32'hC0800000, 4'b0000, 0, "t5_7");
        drain();
        check("t5_stall_cycles", 64'(stall_seen), 64'(3));
        stall_lo = -1;
        stall_hi = -1;

        // Reset with operations in flight
        stall_lo = cyc;
        stall_hi = cyc + 1000;
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 0, "t6_a");
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 0, "t6_b");
        send(32'h3FC00000, 32'h3F800000, 1'b0, 32'h40200000, 4'b0000, 0, "t6_c");
        tick();
        tick();
        check("t6_pre_out_valid", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", 64'(out_valid), 64'(0));
        check("t6_rst_result", 64'(result), 64'(0));
        check("t6_rst_flags", 64'(flags), 64'(0));
        sb_q.delete();
        prev_stall = 0;
        stall_lo   = -1;
        stall_hi   = -1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t6_no_stale", 64'(out_valid), 64'(0));
        end

        // Pipeline works again after reset
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1, "t6_post");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
